// File: rtl/order_queue_ctrl.sv
// order_queue_ctrl: order queue that stores a pushed program and replays it over valid/ready until END_OPCODE
// Ports: axi_clk/axi_rst_n (async active-low); clear empties the queue and aborts issue;
//   push_valid/push_ready/push_data write side; start begins issue from address 0;
//   pop_valid/pop_ready/pop_data issue side; busy = not IDLE; done pulses after the END handshake;
//   level = stored orders; err = sticky push overflow when ORDER_QUEUE_ERR_EN is defined, else 0.
module order_queue_ctrl #(
  parameter int ORDER_W = 256,
  parameter int DEPTH_LOG2 = 9,
  parameter int OPCODE_W = 3,
  parameter int END_OPCODE = 5
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst_n,
  input  logic                  clear,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [ORDER_W-1:0]    push_data,
  input  logic                  start,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [ORDER_W-1:0]    pop_data,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  err
);
  localparam logic [DEPTH_LOG2:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, WAIT} state_t;
  state_t state, state_nx;
  logic [ORDER_W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr, rd_inc;
  logic [DEPTH_LOG2-1:0] rd_ptr, rd_nx;
  logic push_fire, pop_fire, is_end;
  assign push_ready = wr_ptr != CAP;
  assign push_fire = push_valid && push_ready && !clear;
  assign pop_valid = state == HOLD;
  assign pop_fire = pop_valid && pop_ready;
  assign is_end = pop_data[OPCODE_W-1:0] == OPCODE_W'(END_OPCODE);
  // Computed one bit wider so the last address rolls to CAP, which is never below wr_ptr and forces WAIT.
  assign rd_inc = {1'b0, rd_ptr} + 1'b1;
  assign busy = state != IDLE;
  assign level = wr_ptr;
  always_comb begin
    state_nx = state;
    rd_nx = rd_ptr;
    case (state)
      IDLE: if (start) begin
        state_nx = wr_ptr == '0 ? WAIT : FETCH;
        rd_nx = '0;
      end
      FETCH: state_nx = HOLD;
      HOLD: if (pop_ready) begin
        state_nx = is_end ? IDLE : rd_inc < wr_ptr ? FETCH : WAIT;
        rd_nx = is_end ? '0 : rd_inc[DEPTH_LOG2-1:0];
      end
      WAIT: state_nx = wr_ptr > {1'b0, rd_ptr} ? FETCH : WAIT;
      default: state_nx = IDLE;
    endcase
    if (clear) begin
      state_nx = IDLE;
      rd_nx = '0;
    end
  end
  always_ff @(posedge axi_clk or negedge axi_rst_n)
    if (!axi_rst_n) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      pop_data <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      rd_ptr <= rd_nx;
      wr_ptr <= clear ? '0 : wr_ptr + (DEPTH_LOG2+1)'(push_fire);
      done <= !clear && pop_fire && is_end;
      if (state == FETCH) pop_data <= mem[rd_ptr];
    end
  always_ff @(posedge axi_clk)
    if (push_fire) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
`ifdef ORDER_QUEUE_ERR_EN
  always_ff @(posedge axi_clk or negedge axi_rst_n)
    if (!axi_rst_n) err <= 1'b0;
    else if (clear) err <= 1'b0;
    else if (push_valid && !push_ready) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_order_queue_ctrl.sv
// tb_order_queue_ctrl: self-checking bench for order_queue_ctrl with a program-level reference model
module tb_order_queue_ctrl;
  localparam int W = 32;
  localparam int D = 2;
  localparam int CAP = 4;
  localparam logic [2:0] END_OP = 3'd5;
`ifdef ORDER_QUEUE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic axi_clk = 1'b0, axi_rst_n = 1'b0, clear = 1'b0, push_valid = 1'b0, start = 1'b0, pop_ready = 1'b0;
  logic [W-1:0] push_data = '0;
  logic push_ready, pop_valid, busy, done, err;
  logic [W-1:0] pop_data;
  logic [D:0] level;
  logic [W-1:0] prog [$];
  bit err_model = 1'b0;
  int checks = 0, errors = 0;
  always #5 axi_clk = ~axi_clk;
  order_queue_ctrl #(.ORDER_W(W), .DEPTH_LOG2(D), .OPCODE_W(3), .END_OPCODE(5)) dut (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n), .clear(clear),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .start(start), .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .busy(busy), .done(done), .level(level), .err(err)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask
  function automatic logic [W-1:0] word(input logic [2:0] op);
    logic [31:0] r;
    r = $urandom;
    return {r[31:3], op};
  endfunction
  function automatic logic [2:0] rand_op();
    int o;
    o = $urandom_range(0, 6);
    return 3'(o >= 5 ? o + 1 : o);
  endfunction
  task automatic do_push(input logic [W-1:0] w);
    check("push_ready", push_ready, prog.size() < CAP);
    check("level", level, prog.size());
    push_valid = 1'b1;
    push_data = w;
    if (prog.size() < CAP) prog.push_back(w);
    else err_model = ERR_EN;
    cyc();
    push_valid = 1'b0;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    prog.delete();
    err_model = 1'b0;
  endtask
  // Expected issue order: program words from address 0, wrapping at capacity, ending with the first END word.
  task automatic run(input int mode, input int max_hs);
    int idx, hs, stall, budget;
    bit ended, was_stalled;
    logic [W-1:0] held;
    idx = 0; hs = 0; stall = 0; budget = 0; ended = 0; was_stalled = 0; held = '0;
    start = 1'b1;
    pop_ready = 1'b0;
    cyc();
    start = 1'b0;
    while (!ended && hs < max_hs) begin
      if (budget++ > 300) begin
        check("timeout", hs, max_hs);
        break;
      end
      check("done_mid", done, 0);
      check("busy_mid", busy, 1);
      if (was_stalled) begin
        check("stall_valid", pop_valid, 1);
        check("stall_data", pop_data, held);
      end
      pop_ready = (mode == 0) || (mode == 2 ? stall >= 5 : $urandom_range(0, 1) == 1);
      was_stalled = pop_valid && !pop_ready;
      held = pop_data;
      if (pop_valid) begin
        if (pop_ready) begin
          check("pop_data", pop_data, prog[idx]);
          ended = prog[idx][2:0] == END_OP;
          idx = (idx + 1) % CAP;
          hs++;
          stall = 0;
        end else stall++;
      end
      cyc();
    end
    pop_ready = 1'b0;
    if (ended) begin
      check("done", done, 1);
      check("busy_end", busy, 0);
      cyc();
      check("done_pulse", done, 0);
    end
  endtask
  task automatic clear_mid();
    int b;
    b = 0;
    start = 1'b1;
    pop_ready = 1'b0;
    cyc();
    start = 1'b0;
    while (!pop_valid && b < 10) begin
      b++;
      cyc();
    end
    check("cm_hold", pop_valid, 1);
    clear = 1'b1;
    push_valid = 1'b1;
    push_data = word(3'd1);
    cyc();
    clear = 1'b0;
    push_valid = 1'b0;
    prog.delete();
    err_model = 1'b0;
    check("cm_valid", pop_valid, 0);
    check("cm_level", level, 0);
    check("cm_busy", busy, 0);
    check("cm_err", err, 0);
    check("cm_ready", push_ready, 1);
  endtask
  initial begin
    logic [W-1:0] s1, s5;
    int n;
    repeat (3) cyc();
    check("rst_valid", pop_valid, 0);
    check("rst_data", pop_data, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ready", push_ready, 1);
    check("rst_level", level, 0);
    axi_rst_n = 1'b1;
    cyc();
    do_push(word(3'd1));
    do_push(word(3'd2));
    do_push(word(3'd5));
    for (int c = 0; c <= 8; c++) begin
      start = c == 0;
      pop_ready = 1'b1;
      if (c > 0) begin
        check("basic_valid", pop_valid, c == 2 || c == 4 || c == 6);
        if (pop_valid && (c == 2 || c == 4 || c == 6)) check("basic_data", pop_data, prog[c/2-1]);
        check("basic_done", done, c == 7);
      end
      cyc();
    end
    start = 1'b0;
    check("basic_busy", busy, 0);
    check("basic_level", level, 3);
    run(0, 100);
    run(2, 100);
    do_clear();
    s1 = word(3'd1);
    s5 = word(3'd5);
    for (int c = 0; c <= 15; c++) begin
      start = c == 0;
      pop_ready = 1'b1;
      push_valid = c == 4 || c == 10;
      push_data = c == 4 ? s1 : s5;
      if (c == 4) prog.push_back(s1);
      if (c == 10) prog.push_back(s5);
      if (c > 0) begin
        check("stream_valid", pop_valid, c == 7 || c == 13);
        if (pop_valid && (c == 7 || c == 13)) check("stream_data", pop_data, prog[c == 7 ? 0 : 1]);
        check("stream_done", done, c == 14);
      end
      cyc();
    end
    start = 1'b0;
    push_valid = 1'b0;
    check("stream_busy", busy, 0);
    do_clear();
    for (int i = 0; i < 5; i++) do_push(word(i == 3 ? 3'd5 : i == 4 ? 3'd6 : 3'(i + 1)));
    check("full_ready", push_ready, 0);
    check("full_level", level, 4);
    check("full_err", err, err_model);
    run(0, 100);
    check("full_err_kept", err, err_model);
    clear_mid();
    do_push(word(3'd1));
    do_push(word(3'd5));
    clear_mid();
    for (int i = 0; i < CAP; i++) do_push(word(rand_op()));
    run(1, 10);
    do_clear();
    for (int r = 0; r < 6; r++) begin
      do_clear();
      n = $urandom_range(1, CAP);
      for (int i = 0; i < n - 1; i++) do_push(word(rand_op()));
      do_push(word(END_OP));
      run(r % 3, 100);
      run(1, 100);
      check("rand_level", level, n);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/order_queue_ctrl.md
# order_queue_ctrl

Parametrised single-clock order queue for the accelerator's instruction path. It stores a program of packed order words pushed from the AXI configuration side and issues them one at a time over a valid/ready interface to the calculation control logic. It rewinds automatically when it reaches the end-of-task opcode, so the same program can be replayed on every `start`. It also supports streaming, where orders are issued while the program is still being written.

## Interface
Parameters:
- `ORDER_W`, 256: width of one packed order word.
- `DEPTH_LOG2`, 9: address width; capacity is 2**DEPTH_LOG2 orders.
- `OPCODE_W`, 3: opcode field width, located at `order[OPCODE_W-1:0]`.
- `END_OPCODE`, 5: opcode that terminates a task.

Ports:
- `axi_clk`, in, 1: clock; all logic runs on it.
- `axi_rst_n`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: empties the queue and aborts any issue in progress.
- `push_valid`, in, 1: a push order word is offered.
- `push_ready`, out, 1: space is available for a push.
- `push_data`, in, ORDER_W: order word to store.
- `start`, in, 1: begin issuing from address 0.
- `pop_valid`, out, 1: `pop_data` holds an order.
- `pop_ready`, in, 1: consumer accepts the current order.
- `pop_data`, out, ORDER_W: current order word.
- `busy`, out, 1: the state machine is not in IDLE.
- `done`, out, 1: one-cycle pulse when the END order is accepted.
- `level`, out, DEPTH_LOG2+1: number of stored orders, equal to `wr_ptr`.
- `err`, out, 1: sticky push-overflow flag (see Configuration).

## Operation
Storage:
- Internal RAM of 2**DEPTH_LOG2 words × ORDER_W, with synchronous read.
- `wr_ptr` is DEPTH_LOG2+1 bits. `rd_ptr` is DEPTH_LOG2 bits.

Push side:
- `push_ready = (wr_ptr != 2**DEPTH_LOG2)`.
- When `push_valid && push_ready`, the word is written to `wr_ptr` and `wr_ptr` increments.
- Entries are not consumed by issue. The program persists until `clear`.

State machine: IDLE, FETCH, HOLD, WAIT.
- **IDLE**
  - `start` → FETCH with `rd_ptr` = 0.
  - `start` with `level` = 0 → WAIT.
- **FETCH**
  - Issues the RAM read at `rd_ptr`, then → HOLD.
- **HOLD**
  - `pop_valid` = 1.
  - On `pop_ready`, if the opcode equals END_OPCODE: → IDLE, `rd_ptr` ← 0, `done` pulses.
  - On `pop_ready` otherwise: `rd_ptr` increments. Go → FETCH if `rd_ptr+1 < wr_ptr`, else → WAIT.
- **WAIT**
  - Streaming underrun. Stay until `wr_ptr > rd_ptr`, then → FETCH.

Other rules:
- `pop_data` is registered. It is loaded on the FETCH→HOLD transition and held stable while `pop_valid && !pop_ready`.
- `start` outside IDLE is ignored.
- `clear` has priority over everything in the same cycle:
  - `wr_ptr` ← 0, `rd_ptr` ← 0, state ← IDLE, `pop_valid` ← 0.
  - A push in the same cycle is dropped.
  - `err` is cleared.
- `rd_ptr` reaching 2**DEPTH_LOG2−1 and incrementing without END wraps to 0 and enters WAIT. Because `wr_ptr` is full, the queue then re-issues from 0.
- Reset values: state IDLE, `wr_ptr` 0, `rd_ptr` 0, `pop_valid` 0, `pop_data` 0, `done` 0, `busy` 0, `err` 0, `push_ready` 1, `level` 0.

## Timing
- The cycle of `start` in IDLE is cycle 0. FETCH occurs in cycle 1, and `pop_valid` = 1 with valid `pop_data` from cycle 2.
- After a pop handshake in cycle n, the next `pop_valid` appears at cycle n+2. Steady-state throughput is 1 order per 2 cycles.
- `done` is asserted in the cycle after the END handshake, for exactly 1 cycle. `busy` falls in that same cycle.
- A word pushed in cycle k is fetchable from cycle k+1. In WAIT, `pop_valid` rises at k+3.
- `push_ready` and `level` update the cycle after the push.

## Configuration
- `ORDER_QUEUE_ERR_EN` defined:
  - `err` is set (sticky) when `push_valid && !push_ready`.
  - It is cleared only by `clear` or reset.
- `ORDER_QUEUE_ERR_EN` undefined:
  - `err` is tied to 0.
  - Pushes while full are silently dropped.

## Test plan
- **Basic issue:** push 3 orders with opcodes 1, 2, 5, then `start` with `pop_ready`=1. Required: pops at cycles 2, 4 and 6 with opcodes 1, 2, 5; `done` pulses at cycle 7; `busy` = 0 and `level` = 3 afterwards.
- **Replay:** after the basic-issue run, pulse `start` again. Required: the identical 3-order sequence is reissued from address 0.
- **Backpressure:** hold `pop_ready`=0 for 5 cycles in HOLD. Required: `pop_data` is stable and `pop_valid` is held; release gives exactly one handshake per order.
- **Streaming:** `start` with `level`=0, then push opcode 1 at cycle 4 and opcode 5 at cycle 10. Required: pops at cycles 7 and 13, and `done` follows.
- **Full and overflow:** with DEPTH_LOG2=2, push 5 words. Required: `push_ready`=0 after 4 pushes and `level`=4; `err`=1 only when ERR_EN is defined.
- **Clear mid-issue:** assert `clear` in HOLD together with `push_valid`. Required: next cycle `pop_valid`=0, `level`=0, `busy`=0, `err`=0; the push is dropped.
